// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the shift-register fifo and its read-side engine.
// The reader's state encoding lives here so the bench and other blocks can reference it.
package fifo_pkg;

    localparam int unsigned FIFO_DW = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Fifo-pop and beat-stream signals of fifo_stream_reader; out_parity exists only
// when FIFO_RD_PARITY_EN is defined.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned DIN_W  = FIFO_DW,
    parameter int unsigned DOUT_W = 16
) ();

    logic              fifo_empty;
    logic [DIN_W-1:0]  fifo_data;
    logic              fifo_shift_out;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_data;
    logic              out_last;
    logic              busy;
`ifdef FIFO_RD_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_shift_out,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last,
`ifdef FIFO_RD_PARITY_EN
        output out_parity,
`endif
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_shift_out,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last,
`ifdef FIFO_RD_PARITY_EN
        input  out_parity,
`endif
        input  busy
    );

endinterface

// File: rtl/fifo_stream_reader.sv
// Pops 64-bit fifo words and serializes them LSB-first into DOUT_W-bit valid/ready beats.
// Optional FIFO_RD_PARITY_EN adds an even-parity bit per beat.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DIN_W  = FIFO_DW,
    parameter int unsigned DOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 res_n,
    fifo_stream_reader_if.master bus
);

    localparam int unsigned NBEATS = DIN_W / DOUT_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

    if (DIN_W % DOUT_W != 0) begin : g_width_check
        $error("fifo_stream_reader: DIN_W must be a multiple of DOUT_W");
    end

    rd_state_e        state_q, state_d;
    logic [DIN_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic valid;
    logic accept;
    logic end_word;
    logic pop;

    always_comb begin
        valid    = (state_q == SEND);
        accept   = valid & bus.out_ready;
        end_word = accept & (cnt_q == LAST_IDX);
        pop      = res_n & ~bus.fifo_empty & (~valid | end_word);

        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;

        // A pop on the last accept reloads immediately, so words stream without a bubble.
        if (pop) begin
            word_d  = bus.fifo_data;
            cnt_d   = '0;
            state_d = SEND;
        end else if (end_word) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (accept) begin
            word_d = word_q >> DOUT_W;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fifo_shift_out = pop;
    assign bus.out_valid      = valid;
    assign bus.busy           = valid;
    assign bus.out_data       = word_q[DOUT_W-1:0];
    assign bus.out_last       = valid & (cnt_q == LAST_IDX);
`ifdef FIFO_RD_PARITY_EN
    assign bus.out_parity     = ^word_q[DOUT_W-1:0];
`endif

endmodule
